mem_arbiter: RTL and testbench

Arbitrates one single-ported, fixed-latency memory between the pipeline's instruction-fetch port and data (MEM-stage) port. Data accesses have priority; a starvation guard forces an instruction grant after a bounded run of data grants while fetch waits. Sits between the pipelined datapath's i_/d_ memory signals and the shared memory model, and supplies the ready pulses the hazard control unit uses to stall IF/MEM.

---
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported, fixed-latency memory between the instruction-fetch
// port (i_*) and the MEM-stage data port (d_*). Data accesses win arbitration.
// A starvation guard hands the memory to fetch once STARVE_LIMIT consecutive
// data grants have been issued while fetch was waiting. Only one transaction
// is outstanding at a time: IDLE -> BUSY (LATENCY cycles) -> RESP -> IDLE.
//
// Parameters
//   WORD_SIZE     address/data width
//   LATENCY       memory cycles per access (>= 1)
//   STARVE_LIMIT  data grants tolerated while fetch is pending (>= 1)
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   i_req, i_addr         fetch request (held until i_ready) and address
//   i_ready, i_rdata      one-cycle completion pulse and fetched word
//   d_read, d_write       data request (held until d_ready)
//   d_addr, d_wdata       data address and write data
//   d_ready, d_rdata      one-cycle completion pulse and read data
//   mem_read, mem_write   memory strobes, high for the whole BUSY window
//   mem_addr, mem_wdata   memory address/write data, hold outside BUSY
//   mem_rdata             memory read data, valid on the last BUSY cycle
//   num_i_grant           fetch grants since reset (wrapping)
//   num_d_grant           data grants since reset (wrapping)
//   proto_err             sticky: d_read and d_write granted together
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ready,
    output logic [WORD_SIZE-1:0] i_rdata,

    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ready,
    output logic [WORD_SIZE-1:0] d_rdata,

    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,

    output logic [WORD_SIZE-1:0] num_i_grant,
    output logic [WORD_SIZE-1:0] num_d_grant,
    output logic                 proto_err
);

    // Wait counter counts LATENCY-1 down to 0; starve counter saturates at
    // STARVE_LIMIT.
    localparam int WAIT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [WAIT_W-1:0]   WAIT_INIT  = WAIT_W'(LATENCY - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q;
    logic                  owner_d_q;      // 1: data port owns the transaction
    logic                  is_write_q;
    logic [WAIT_W-1:0]     wait_cnt_q;
    logic [STARVE_W-1:0]   starve_cnt_q;

    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [WORD_SIZE-1:0]  mem_addr_q;
    logic [WORD_SIZE-1:0]  mem_wdata_q;

    logic                  i_ready_q;
    logic                  d_ready_q;
    logic [WORD_SIZE-1:0]  i_rdata_q;
    logic [WORD_SIZE-1:0]  d_rdata_q;

    logic [WORD_SIZE-1:0]  num_i_grant_q;
    logic [WORD_SIZE-1:0]  num_d_grant_q;
    logic                  proto_err_q;

    // Arbitration decode; only consumed by the IDLE branch of the FSM, so no
    // request input reaches an output without passing through a register.
    logic d_req;
    logic grant_i;
    logic grant_d;
    logic grant_wr;

    always_comb begin
        d_req    = d_read | d_write;
        grant_i  = i_req & (~d_req | (starve_cnt_q == STARVE_MAX));
        grant_d  = d_req & ~grant_i;
        // A simultaneous read+write request is carried out as a write.
        grant_wr = grant_d & d_write;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            owner_d_q     <= 1'b0;
            is_write_q    <= 1'b0;
            wait_cnt_q    <= '0;
            starve_cnt_q  <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            i_ready_q     <= 1'b0;
            d_ready_q     <= 1'b0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            num_i_grant_q <= '0;
            num_d_grant_q <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_i || grant_d) begin
                        state_q     <= BUSY;
                        owner_d_q   <= grant_d;
                        is_write_q  <= grant_wr;
                        wait_cnt_q  <= WAIT_INIT;
                        mem_read_q  <= ~grant_wr;
                        mem_write_q <= grant_wr;
                        mem_addr_q  <= grant_d ? d_addr : i_addr;
                        if (grant_d) begin
                            mem_wdata_q   <= d_wdata;
                            num_d_grant_q <= num_d_grant_q + WORD_SIZE'(1);
                            // Count data grants only while fetch is actually
                            // waiting; an uncontested data grant clears the run.
                            if (i_req) begin
                                if (starve_cnt_q != STARVE_MAX) begin
                                    starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
                                end
                            end else begin
                                starve_cnt_q <= '0;
                            end
                            if (d_read && d_write) begin
                                proto_err_q <= 1'b1;
                            end
                        end else begin
                            num_i_grant_q <= num_i_grant_q + WORD_SIZE'(1);
                            starve_cnt_q  <= '0;
                        end
                    end
                end

                BUSY: begin
                    if (wait_cnt_q == '0) begin
                        state_q     <= RESP;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (owner_d_q) begin
                            d_ready_q <= 1'b1;
                            if (!is_write_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                        end else begin
                            i_ready_q <= 1'b1;
                            i_rdata_q <= mem_rdata;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
                    end
                end

                RESP: begin
                    // Turnaround cycle: ready pulse ends, no arbitration here.
                    state_q   <= IDLE;
                    i_ready_q <= 1'b0;
                    d_ready_q <= 1'b0;
                end

                default: begin
                    state_q     <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    i_ready_q   <= 1'b0;
                    d_ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign i_ready     = i_ready_q;
    assign i_rdata     = i_rdata_q;
    assign d_ready     = d_ready_q;
    assign d_rdata     = d_rdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign num_i_grant = num_i_grant_q;
    assign num_d_grant = num_d_grant_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter (WORD_SIZE=16, LATENCY=2, STARVE_LIMIT=3).
// The stimulus thread drives requests, checks per-cycle strobe/ready timing,
// and pushes the expected completion (owner + read data) into a queue; a
// separate monitor pops and compares whenever a ready pulse appears.
// Memory model: read data = 0xABCD at address 0x0010, else address ^ 0x5A5A.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ready;
    logic [15:0] i_rdata;
    logic        d_read;
    logic        d_write;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ready;
    logic [15:0] d_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] num_i_grant;
    logic [15:0] num_d_grant;
    logic        proto_err;

    int tests;
    int fails;

    typedef struct {
        bit          is_d;
        logic [15:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    mem_arbiter #(
        .WORD_SIZE   (16),
        .LATENCY     (2),
        .STARVE_LIMIT(3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ready    (i_ready),
        .i_rdata    (i_rdata),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .num_i_grant(num_i_grant),
        .num_d_grant(num_d_grant),
        .proto_err  (proto_err)
    );

    assign mem_rdata = (mem_addr == 16'h0010) ? 16'hABCD : (mem_addr ^ 16'h5A5A);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every ready pulse must match the next expected entry.
    always @(negedge clk) begin
        if (reset_n && (i_ready || d_ready)) begin
            if (i_ready && d_ready) begin
                chk1("both_ready", 1'b1, 1'b0);
            end else if (exp_q.size() == 0) begin
                chk1("unexpected_ready", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk1("sb_owner_is_d", d_ready, e.is_d);
                if (e.is_d) chk("sb_d_rdata", d_rdata, e.rdata);
                else        chk("sb_i_rdata", i_rdata, e.rdata);
            end
        end
    end

    // One cycle: check strobes/readies at the negedge, then drop any request
    // whose ready was just seen, just after the following rising edge.
    task automatic step(input string nm, input bit er, input bit ew,
                        input bit eir, input bit edr, input bit ca = 1'b0,
                        input logic [15:0] ea = 16'h0, input logic [15:0] ewd = 16'h0);
        bit si, sd;
        @(negedge clk);
        chk1({nm, "_mem_read"}, mem_read, er);
        chk1({nm, "_mem_write"}, mem_write, ew);
        chk1({nm, "_i_ready"}, i_ready, eir);
        chk1({nm, "_d_ready"}, d_ready, edr);
        if (ca) begin
            chk({nm, "_mem_addr"}, mem_addr, ea);
            if (ew) chk({nm, "_mem_wdata"}, mem_wdata, ewd);
        end
        si = i_ready;
        sd = d_ready;
        @(posedge clk);
        #1;
        if (si) i_req = 1'b0;
        if (sd) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
    endtask

    task automatic push(input bit is_d, input logic [15:0] rd);
        exp_t e;
        e.is_d  = is_d;
        e.rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        int dk;
        bit si, sd;
        tests = 0;
        fails = 0;
        reset_n = 1'b1;
        i_req = 1'b0; i_addr = 16'h0;
        d_read = 1'b0; d_write = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;

        // ---- reset state ----
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk1("rst_i_ready", i_ready, 1'b0);
        chk1("rst_d_ready", d_ready, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);
        chk("rst_i_rdata", i_rdata, 16'h0);
        chk("rst_d_rdata", d_rdata, 16'h0);
        chk("rst_num_i", num_i_grant, 16'h0);
        chk("rst_num_d", num_d_grant, 16'h0);
        chk1("rst_proto_err", proto_err, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- single fetch ----
        i_req = 1'b1; i_addr = 16'h0010;
        push(1'b0, 16'hABCD);
        step("f_c0", 0, 0, 0, 0);
        step("f_c1", 1, 0, 0, 0, 1'b1, 16'h0010);
        step("f_c2", 1, 0, 0, 0, 1'b1, 16'h0010);
        step("f_c3", 0, 0, 1, 0);
        step("f_c4", 0, 0, 0, 0);
        chk("f_i_rdata", i_rdata, 16'hABCD);
        chk("f_num_i", num_i_grant, 16'd1);

        // ---- simultaneous fetch + data read: data first ----
        i_req = 1'b1; i_addr = 16'h0030;
        d_read = 1'b1; d_addr = 16'h0040;
        push(1'b1, 16'h5A1A);
        push(1'b0, 16'h5A6A);
        step("p_c0", 0, 0, 0, 0);
        step("p_c1", 1, 0, 0, 0, 1'b1, 16'h0040);
        step("p_c2", 1, 0, 0, 0);
        step("p_c3", 0, 0, 0, 1);
        step("p_c4", 0, 0, 0, 0);
        step("p_c5", 1, 0, 0, 0, 1'b1, 16'h0030);
        step("p_c6", 1, 0, 0, 0);
        step("p_c7", 0, 0, 1, 0);
        step("p_c8", 0, 0, 0, 0);

        // ---- data write: d_rdata keeps the last read value ----
        d_write = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        push(1'b1, 16'h5A1A);
        step("w_c0", 0, 0, 0, 0);
        step("w_c1", 0, 1, 0, 0, 1'b1, 16'h0020, 16'h1234);
        step("w_c2", 0, 1, 0, 0, 1'b1, 16'h0020, 16'h1234);
        step("w_c3", 0, 0, 0, 1, 1'b1, 16'h0020);
        step("w_c4", 0, 0, 0, 0);
        chk("w_d_rdata", d_rdata, 16'h5A1A);
        chk1("w_proto_err", proto_err, 1'b0);

        // ---- read+write together: performed as write, sticky proto_err ----
        d_read = 1'b1; d_write = 1'b1; d_addr = 16'h0022; d_wdata = 16'h5555;
        push(1'b1, 16'h5A1A);
        step("rw_c0", 0, 0, 0, 0);
        step("rw_c1", 0, 1, 0, 0, 1'b1, 16'h0022, 16'h5555);
        step("rw_c2", 0, 1, 0, 0);
        step("rw_c3", 0, 0, 0, 1);
        step("rw_c4", 0, 0, 0, 0);
        chk1("rw_proto_err", proto_err, 1'b1);
        i_req = 1'b1; i_addr = 16'h0010;
        push(1'b0, 16'hABCD);
        step("rf_c0", 0, 0, 0, 0);
        step("rf_c1", 1, 0, 0, 0);
        step("rf_c2", 1, 0, 0, 0);
        step("rf_c3", 0, 0, 1, 0);
        step("rf_c4", 0, 0, 0, 0);
        chk1("rf_proto_sticky", proto_err, 1'b1);
        chk("rf_num_i", num_i_grant, 16'd3);
        chk("rf_num_d", num_d_grant, 16'd3);

        // ---- reset during second BUSY cycle ----
        i_req = 1'b1; i_addr = 16'h0050;
        step("r_c0", 0, 0, 0, 0);
        step("r_c1", 1, 0, 0, 0, 1'b1, 16'h0050);
        reset_n = 1'b0;
        i_req = 1'b0;
        #1;
        chk1("r_mem_read_drop", mem_read, 1'b0);
        chk1("r_i_ready", i_ready, 1'b0);
        chk("r_num_i", num_i_grant, 16'h0);
        chk("r_num_d", num_d_grant, 16'h0);
        chk1("r_proto_err", proto_err, 1'b0);
        chk("r_i_rdata", i_rdata, 16'h0);
        chk("r_d_rdata", d_rdata, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step("r_q0", 0, 0, 0, 0);
        step("r_q1", 0, 0, 0, 0);
        step("r_q2", 0, 0, 0, 0);
        d_read = 1'b1; d_addr = 16'h0060;
        push(1'b1, 16'h5A3A);
        step("r_n0", 0, 0, 0, 0);
        step("r_n1", 1, 0, 0, 0, 1'b1, 16'h0060);
        step("r_n2", 1, 0, 0, 0);
        step("r_n3", 0, 0, 0, 1);
        step("r_n4", 0, 0, 0, 0);
        chk("r_n_num_d", num_d_grant, 16'd1);
        chk("r_n_num_i", num_i_grant, 16'd0);

        // ---- starvation guard: D,D,D,I,D,D,D,I ----
        do_reset();
        push(1'b1, 16'h5B5A);
        push(1'b1, 16'h5B5B);
        push(1'b1, 16'h5B58);
        push(1'b0, 16'h585A);
        push(1'b1, 16'h5B59);
        push(1'b1, 16'h5B5E);
        push(1'b1, 16'h5B5F);
        push(1'b0, 16'h585A);
        i_req = 1'b1; i_addr = 16'h0200;
        d_read = 1'b1; d_addr = 16'h0100;
        n = 0;
        dk = 0;
        for (int cyc = 0; cyc < 300 && n < 8; cyc++) begin
            @(negedge clk);
            si = i_ready;
            sd = d_ready;
            @(posedge clk);
            #1;
            if (si || sd) n++;
            if (sd) begin
                dk++;
                d_addr = 16'h0100 + 16'(dk);
            end
            if (n == 8) begin
                i_req  = 1'b0;
                d_read = 1'b0;
            end
        end
        chk("s_completions", 16'(n), 16'd8);
        i_req  = 1'b0;
        d_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("s_num_d", num_d_grant, 16'd6);
        chk("s_num_i", num_i_grant, 16'd2);
        chk("s_queue_left", 16'(exp_q.size()), 16'd0);

        // ---- proto_err cleared only by reset ----
        chk1("end_proto_err", proto_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
